// File: rtl/strait_recovery_pkg.sv
// -----------------------------------------------------------------------------
// strait_recovery_pkg
//   Shared types for the faulty-PE self-recovery sequencer.
//   - state_t      : sequencer state encoding, also exported on the debug port
//   - match_kind_t : decoded storage result for one weight row
//   - addr_width() : row-index width for an N x N systolic array
// -----------------------------------------------------------------------------
package strait_recovery_pkg;

  localparam int unsigned DEFAULT_SYSTOLIC_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WRITE  = 3'd2,
    SETTLE = 3'd3,
    FETCH  = 3'd4,
    ISSUE  = 3'd5,
    RESULT = 3'd6,
    FIN    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    MK_NONE    = 2'd0,
    MK_FAILED  = 2'd1,
    MK_SUCCESS = 2'd2,
    MK_BOTH    = 2'd3
  } match_kind_t;

  // Row index width. Kept at least 1 bit so a degenerate 1x1 array still
  // gets a legal vector.
  function automatic int unsigned addr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Storage raises exactly one of the two result lines; anything else is a
  // protocol violation that the sequencer treats as a failed recovery.
  function automatic match_kind_t decode_match(input logic success,
                                               input logic failed);
    match_kind_t kind;
    case ({success, failed})
      2'b10:   kind = MK_SUCCESS;
      2'b01:   kind = MK_FAILED;
      2'b11:   kind = MK_BOTH;
      default: kind = MK_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/healthy_row_picker.sv
// -----------------------------------------------------------------------------
// healthy_row_picker
//   Combinational priority encoder: returns the lowest-index set bit of the
//   free-row mask. Used to hand out spare healthy PE rows in ascending order.
// Ports
//   free_mask_i  in  N   1 = row is healthy and not yet allocated
//   found_o      out 1   at least one free row exists
//   index_o      out AW  lowest free row index (0 when found_o = 0)
// -----------------------------------------------------------------------------
module healthy_row_picker #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 3
) (
  input  logic [N-1:0]  free_mask_i,
  output logic          found_o,
  output logic [AW-1:0] index_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (free_mask_i[i]) begin
        found_o = 1'b1;
        index_o = AW'(i);
      end
    end
  end

endmodule

// File: rtl/faulty_pe_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// faulty_pe_alloc_ctrl
//   Sequencer for the faulty-PE storage allocator during self-recovery.
//   One pass: load fault patterns from eNVM into the storage, then for every
//   logical weight row 0..N-1 fetch its zero-weight flags, issue one
//   allocation request, and write the resulting logical->physical row entry
//   into the Mapping Table. Matched rows reuse the reported faulty row;
//   unmatched rows take the lowest free healthy row.
// Ports
//   clk, rst            clock / synchronous active-high reset
//   start               pulse, begins a pass (ignored while busy)
//   envm_valid          eNVM patterns present on the storage write bus
//   stor_wr_en          1-cycle storage write strobe
//   wt_req / wt_row     zero-weight flag request for row wt_row
//   wt_ack              flags valid this cycle
//   stor_weight_valid   1-cycle pulse to storage, flags held
//   match_success/failed, faulty_row_addr   storage result (1 cycle later)
//   faulty_rows_mask    static faulty-row map from storage
//   map_wr_en / map_logical / map_physical  Mapping Table write port
//   busy, done, recovery_ok, recovery_fail  pass status
//   dbg_state           current sequencer state
//
// Flag-fetch handshake: wt_req is the valid, wt_ack the ready. Once wt_req
// rises in FETCH it stays high with wt_row unchanged until the cycle in which
// wt_ack is sampled high; that cycle is the transfer and wt_req drops in the
// next cycle (ISSUE). wt_ack in any other state has no effect.
// -----------------------------------------------------------------------------
module faulty_pe_alloc_ctrl
  import strait_recovery_pkg::*;
#(
  parameter int unsigned SYSTOLIC_SIZE = DEFAULT_SYSTOLIC_SIZE,
  parameter int unsigned ADDR_WIDTH    = addr_width(SYSTOLIC_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     envm_valid,
  output logic                     stor_wr_en,
  output logic                     wt_req,
  output logic [ADDR_WIDTH-1:0]    wt_row,
  input  logic                     wt_ack,
  output logic                     stor_weight_valid,
  input  logic                     match_success,
  input  logic                     match_failed,
  input  logic [ADDR_WIDTH-1:0]    faulty_row_addr,
  input  logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask,
  output logic                     map_wr_en,
  output logic [ADDR_WIDTH-1:0]    map_logical,
  output logic [ADDR_WIDTH-1:0]    map_physical,
  output logic                     busy,
  output logic                     done,
  output logic                     recovery_ok,
  output logic                     recovery_fail,
  output state_t                   dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    row_q, row_d;
  logic [SYSTOLIC_SIZE-1:0] used_q, used_d;
  logic                     fail_q, fail_d;
  logic                     ok_q, ok_d;
  logic                     map_wr_q, map_wr_d;
  logic [ADDR_WIDTH-1:0]    map_log_q, map_log_d;
  logic [ADDR_WIDTH-1:0]    map_phys_q, map_phys_d;

  logic                     pick_found;
  logic [ADDR_WIDTH-1:0]    pick_index;
  logic [SYSTOLIC_SIZE-1:0] free_mask;
  match_kind_t              result_kind;

  // Healthy rows that no earlier logical row in this pass has claimed.
  assign free_mask   = ~faulty_rows_mask & ~used_q;
  assign result_kind = decode_match(match_success, match_failed);

  healthy_row_picker #(
    .N  (SYSTOLIC_SIZE),
    .AW (ADDR_WIDTH)
  ) u_picker (
    .free_mask_i (free_mask),
    .found_o     (pick_found),
    .index_o     (pick_index)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= '0;
      used_q     <= '0;
      fail_q     <= 1'b0;
      ok_q       <= 1'b0;
      map_wr_q   <= 1'b0;
      map_log_q  <= '0;
      map_phys_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      used_q     <= used_d;
      fail_q     <= fail_d;
      ok_q       <= ok_d;
      map_wr_q   <= map_wr_d;
      map_log_q  <= map_log_d;
      map_phys_q <= map_phys_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    used_d     = used_q;
    fail_d     = fail_q;
    ok_d       = ok_q;
    map_wr_d   = 1'b0;
    map_log_d  = map_log_q;
    map_phys_d = map_phys_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Status stays visible from the previous pass until a new one starts.
          state_d = LOAD;
          row_d   = '0;
          used_d  = '0;
          fail_d  = 1'b0;
          ok_d    = 1'b0;
        end
      end

      LOAD: begin
        if (envm_valid) begin
          state_d = WRITE;
        end
      end

      WRITE:  state_d = SETTLE;

      // One idle cycle so the storage has absorbed the fault patterns before
      // the first row's flags are presented.
      SETTLE: state_d = FETCH;

      FETCH: begin
        if (wt_ack) begin
          state_d = ISSUE;
        end
      end

      ISSUE:  state_d = RESULT;

      RESULT: begin
        map_log_d = row_q;
        state_d   = FIN;
        unique case (result_kind)
          MK_SUCCESS: begin
            map_wr_d   = 1'b1;
            map_phys_d = faulty_row_addr;
          end
          MK_FAILED: begin
            if (pick_found) begin
              map_wr_d   = 1'b1;
              map_phys_d = pick_index;
              used_d     = used_q | (SYSTOLIC_SIZE'(1) << pick_index);
            end else begin
              fail_d = 1'b1;
            end
          end
          default: begin
            fail_d = 1'b1;
          end
        endcase
        // Advance only on a mapped row; the counter stops at the last row
        // rather than wrapping back to 0.
        if (map_wr_d && (row_q != LAST_ROW)) begin
          row_d   = row_q + ADDR_WIDTH'(1);
          state_d = FETCH;
        end
      end

      FIN: begin
        ok_d    = ~fail_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign stor_wr_en        = (state_q == WRITE);
  assign wt_req            = (state_q == FETCH);
  assign wt_row            = row_q;
  assign stor_weight_valid = (state_q == ISSUE);
  assign map_wr_en         = map_wr_q;
  assign map_logical       = map_log_q;
  assign map_physical      = map_phys_q;
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == FIN);
  assign recovery_ok       = ok_q;
  assign recovery_fail     = fail_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_faulty_pe_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_faulty_pe_alloc_ctrl
//   Directed bench for the recovery sequencer. A small behavioural storage
//   model answers flag requests (programmable ack delay per row) and returns
//   per-row match results one cycle after stor_weight_valid. A monitor logs
//   Mapping Table writes; the stimulus block compares them with exp_q.
// -----------------------------------------------------------------------------
module tb_faulty_pe_alloc_ctrl;
  import strait_recovery_pkg::*;

  localparam int N  = 8;
  localparam int AW = 3;

  localparam int R_FAIL = 0;
  localparam int R_SUCC = 1;
  localparam int R_BOTH = 2;
  localparam int R_NONE = 3;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT signals
  logic          start = 1'b0;
  logic          envm_valid = 1'b0;
  logic          stor_wr_en;
  logic          wt_req;
  logic [AW-1:0] wt_row;
  logic          wt_ack = 1'b0;
  logic          stor_weight_valid;
  logic          match_success = 1'b0;
  logic          match_failed = 1'b0;
  logic [AW-1:0] faulty_row_addr = '0;
  logic [N-1:0]  faulty_rows_mask = '0;
  logic          map_wr_en;
  logic [AW-1:0] map_logical;
  logic [AW-1:0] map_physical;
  logic          busy;
  logic          done;
  logic          recovery_ok;
  logic          recovery_fail;
  state_t        dbg_state;

  faulty_pe_alloc_ctrl #(.SYSTOLIC_SIZE(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .envm_valid        (envm_valid),
    .stor_wr_en        (stor_wr_en),
    .wt_req            (wt_req),
    .wt_row            (wt_row),
    .wt_ack            (wt_ack),
    .stor_weight_valid (stor_weight_valid),
    .match_success     (match_success),
    .match_failed      (match_failed),
    .faulty_row_addr   (faulty_row_addr),
    .faulty_rows_mask  (faulty_rows_mask),
    .map_wr_en         (map_wr_en),
    .map_logical       (map_logical),
    .map_physical      (map_physical),
    .busy              (busy),
    .done              (done),
    .recovery_ok       (recovery_ok),
    .recovery_fail     (recovery_fail),
    .dbg_state         (dbg_state)
  );

  // ---------------------------------------------------------------- storage model
  int            resp_tab [N];
  logic [AW-1:0] addr_tab [N];
  int            ack_dly  [N];

  logic          wv_prev  = 1'b0;
  logic [AW-1:0] row_prev = '0;
  int            ack_cnt  = 0;
  logic          pend_req = 1'b0;
  logic [AW-1:0] pend_row = '0;
  int            req_viol = 0;

  always @(negedge clk) begin
    // A request left unacknowledged must still be present on the same row.
    if (pend_req && ((wt_req !== 1'b1) || (wt_row !== pend_row))) req_viol++;
    match_success   = wv_prev && ((resp_tab[row_prev] == R_SUCC) || (resp_tab[row_prev] == R_BOTH));
    match_failed    = wv_prev && ((resp_tab[row_prev] == R_FAIL) || (resp_tab[row_prev] == R_BOTH));
    faulty_row_addr = wv_prev ? addr_tab[row_prev] : '0;
    wv_prev  = (stor_weight_valid === 1'b1);
    row_prev = wt_row;
    if (wt_req === 1'b1) begin
      if (ack_cnt == ack_dly[wt_row]) begin
        wt_ack   = 1'b1;
        ack_cnt  = 0;
        pend_req = 1'b0;
      end else begin
        wt_ack   = 1'b0;
        ack_cnt++;
        pend_req = 1'b1;
        pend_row = wt_row;
      end
    end else begin
      wt_ack   = 1'b0;
      ack_cnt  = 0;
      pend_req = 1'b0;
    end
  end

  // ---------------------------------------------------------------- monitor
  logic [2*AW-1:0] got_q[$];
  int              t_q[$];
  int              cyc = 0;
  int              wv_cnt  [N] = '{default: 0};
  int              req_cnt [N] = '{default: 0};
  int              wr_cnt = 0;
  int              done_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (map_wr_en === 1'b1) begin
      got_q.push_back({map_logical, map_physical});
      t_q.push_back(cyc);
    end
    if (stor_weight_valid === 1'b1) wv_cnt[wt_row]++;
    if (wt_req === 1'b1) req_cnt[wt_row]++;
    if (stor_wr_en === 1'b1) wr_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  // ---------------------------------------------------------------- scoreboard
  logic [2*AW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int base_got, base_wr, base_done;
  int base_wv  [N];
  int base_req [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_tables(input int resp);
    for (int i = 0; i < N; i++) begin
      resp_tab[i] = resp;
      addr_tab[i] = '0;
      ack_dly[i]  = 0;
    end
  endtask

  task automatic exp_identity();
    exp_q = {};
    for (int i = 0; i < N; i++) exp_q.push_back({AW'(i), AW'(i)});
  endtask

  task automatic begin_pass();
    base_got  = got_q.size();
    base_wr   = wr_cnt;
    base_done = done_cnt;
    base_wv   = wv_cnt;
    base_req  = req_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((done !== 1'b1) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic wait_fetch_row(input string tag, input int row);
    int n = 0;
    while (!((wt_req === 1'b1) && (wt_row === AW'(row))) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check(tag, wt_row, row);
  endtask

  task automatic check_maps(input string tag);
    int n = got_q.size() - base_got;
    check({tag, "_count"}, n, exp_q.size());
    if (n == exp_q.size()) begin
      for (int i = 0; i < n; i++)
        check($sformatf("%s_map%0d", tag, i), got_q[base_got + i], exp_q[i]);
    end
  endtask

  task automatic check_status(input string tag, input logic ok, input logic fl);
    check({tag, "_ok"},   recovery_ok,   ok);
    check({tag, "_fail"}, recovery_fail, fl);
    check({tag, "_busy"}, busy,          0);
    check({tag, "_idle"}, dbg_state,     IDLE);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    set_tables(R_FAIL);

    // Reset state
    tick(3);
    check("rst_state", dbg_state, IDLE);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_ok",    recovery_ok, 0);
    check("rst_fail",  recovery_fail, 0);
    check("rst_map",   map_wr_en, 0);
    check("rst_req",   wt_req, 0);
    check("rst_row",   wt_row, 0);
    check("rst_swr",   stor_wr_en, 0);
    check("rst_wv",    stor_weight_valid, 0);
    rst = 1'b0;
    tick(1);

    // A: no faults, every request fails -> identity mapping
    faulty_rows_mask = '0;
    begin_pass();
    check("a_busy", busy, 1);
    tick(2);
    check("a_load_wait", dbg_state, LOAD);
    check("a_no_swr", stor_wr_en, 0);
    envm_valid = 1'b1;
    wait_done("a_done", 200);
    tick(1);
    check_status("a", 1'b1, 1'b0);
    exp_identity();
    check_maps("a");
    check("a_swr_pulses", wr_cnt - base_wr, 1);
    if (got_q.size() - base_got == N)
      check("a_row_latency", t_q[base_got + N - 1] - t_q[base_got], 3 * (N - 1));
    for (int i = 0; i < N; i++)
      check($sformatf("a_wv_row%0d", i), wv_cnt[i] - base_wv[i], 1);

    // B: faulty rows {2,5}; rows 3 and 6 match onto them
    faulty_rows_mask = 8'b0010_0100;
    resp_tab[3] = R_SUCC; addr_tab[3] = 3'd2;
    resp_tab[6] = R_SUCC; addr_tab[6] = 3'd5;
    begin_pass();
    check("b_ok_cleared", recovery_ok, 0);
    wait_done("b_done", 200);
    tick(1);
    check_status("b", 1'b1, 1'b0);
    exp_q = {6'o00, 6'o11, 6'o23, 6'o32, 6'o44, 6'o56, 6'o65, 6'o77};
    check_maps("b");

    // C: only row 7 healthy, all requests fail -> row 1 exhausts spares
    set_tables(R_FAIL);
    faulty_rows_mask = 8'b0111_1111;
    begin_pass();
    wait_done("c_done", 200);
    tick(1);
    check_status("c", 1'b0, 1'b1);
    exp_q = {6'o07};
    check_maps("c");
    check("c_wv_row1", wv_cnt[1] - base_wv[1], 1);
    check("c_wv_row2", wv_cnt[2] - base_wv[2], 0);
    check("c_done_pulses", done_cnt - base_done, 1);

    // D: wt_ack held off 4 cycles on row 2
    set_tables(R_FAIL);
    faulty_rows_mask = '0;
    ack_dly[2] = 4;
    begin_pass();
    wait_done("d_done", 200);
    tick(1);
    check_status("d", 1'b1, 1'b0);
    exp_identity();
    check_maps("d");
    check("d_req_stable", req_viol, 0);
    check("d_req_cycles_row2", req_cnt[2] - base_req[2], 5);
    check("d_req_cycles_row3", req_cnt[3] - base_req[3], 1);
    check("d_wv_row2", wv_cnt[2] - base_wv[2], 1);

    // E: reset while fetching row 4, then a clean pass
    set_tables(R_FAIL);
    begin_pass();
    wait_fetch_row("e_reach_row4", 4);
    rst = 1'b1;
    @(negedge clk);
    check("e_rst_idle", dbg_state, IDLE);
    check("e_rst_busy", busy, 0);
    check("e_rst_map",  map_wr_en, 0);
    check("e_rst_req",  wt_req, 0);
    rst = 1'b0;
    tick(5);
    check("e_writes_before_rst", got_q.size() - base_got, 4);
    check("e_wv_row4", wv_cnt[4] - base_wv[4], 0);
    check_status("e_abort", 1'b0, 1'b0);
    begin_pass();
    wait_done("e2_done", 200);
    tick(1);
    check_status("e2", 1'b1, 1'b0);
    exp_identity();
    check_maps("e2");

    // start together with rst: reset wins
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check("sr_idle", dbg_state, IDLE);
    check("sr_busy", busy, 0);
    tick(1);
    check("sr_still_idle", dbg_state, IDLE);

    // F: start mid-pass is ignored; row 1 reports both results
    set_tables(R_FAIL);
    resp_tab[1] = R_BOTH;
    begin_pass();
    wait_fetch_row("f_reach_row1", 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("f_start_ignored", dbg_state, ISSUE);
    wait_done("f_done", 200);
    tick(6);
    check_status("f", 1'b0, 1'b1);
    exp_q = {6'o00};
    check_maps("f");
    check("f_done_pulses", done_cnt - base_done, 1);
    check("f_swr_pulses", wr_cnt - base_wr, 1);

    // G: row 0 reports neither result
    set_tables(R_FAIL);
    resp_tab[0] = R_NONE;
    begin_pass();
    wait_done("g_done", 200);
    tick(1);
    check_status("g", 1'b0, 1'b1);
    exp_q = {};
    check_maps("g");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
